// File: rtl/matrix_generate_nxn_if.sv
// Pixel stream in, K x K window stream out, for the sliding-window generator.
// The design drives the slave side, the pixel source drives the master side.
interface matrix_generate_nxn_if #(
  parameter int DW = 8,
  parameter int K  = 3
);
  logic            pre_frame_vsync;
  logic            pre_frame_hsync;
  logic            pre_frame_valid;
  logic [DW-1:0]   pre_img;
  logic            matrix_frame_vsync;
  logic            matrix_frame_hsync;
  logic            matrix_frame_valid;
  logic [K*K*DW-1:0] matrix_data;
  logic            line_overflow;

  modport master (
    output pre_frame_vsync, pre_frame_hsync,
    output pre_frame_valid, pre_img,
    input  matrix_frame_vsync, matrix_frame_hsync,
    input  matrix_frame_valid, matrix_data,
    input  line_overflow
  );

  modport slave (
    input  pre_frame_vsync, pre_frame_hsync,
    input  pre_frame_valid, pre_img,
    output matrix_frame_vsync, matrix_frame_hsync,
    output matrix_frame_valid, matrix_data,
    output line_overflow
  );
endinterface

// File: rtl/matrix_generate_nxn.sv
// Raster stream to trailing K x K window, K-1 cascaded line buffers,
// top/left border padded with zeros or replicated edge pixels.
module matrix_generate_nxn #(
  parameter int DW     = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 640,
  parameter int BORDER = 0
) (
  input logic clk,
  input logic rst_n,
  matrix_generate_nxn_if.slave io
);
  localparam int AW = $clog2(IMG_W + 1);
  localparam int IW = $clog2(IMG_W);
  localparam int RW = $clog2(K);
  localparam int L  = K - 1;

  typedef logic [DW-1:0] pix_t;

  logic          vs_q, hs_q;
  logic [AW-1:0] col, cur;
  logic [IW-1:0] addr;
  logic [RW-1:0] row, row_cur;
  logic          vs_rise, hs_rise, hs_fall;
  logic          overflow;

  always_comb begin
    vs_rise = io.pre_frame_vsync & ~vs_q;
    hs_rise = io.pre_frame_hsync & ~hs_q;
    hs_fall = ~io.pre_frame_hsync & hs_q;
    cur     = hs_rise ? '0 : col;
    row_cur = vs_rise ? '0 : row;
    // col counts one past the last slot so the first extra pixel is seen
    addr    = (cur == AW'(IMG_W)) ? IW'(IMG_W - 1) : cur[IW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b0;
      hs_q     <= 1'b0;
      col      <= '0;
      row      <= '0;
      overflow <= 1'b0;
    end else begin
      vs_q <= io.pre_frame_vsync;
      hs_q <= io.pre_frame_hsync;
      col  <= cur + AW'(io.pre_frame_valid
                        && cur != AW'(IMG_W));
      if (vs_rise)
        row <= '0;
      else if (hs_fall && row != RW'(K - 1))
        row <= row + 1'b1;
      if (vs_rise)
        overflow <= 1'b0;
      else if (io.pre_frame_valid && cur == AW'(IMG_W))
        overflow <= 1'b1;
    end
  end

  pix_t          mem [L][IMG_W];
  pix_t          line_d [K];
  logic          valid_d1, hs_d1, vs_d1, first_d1;
  logic [RW-1:0] row_d1;
  logic [IW-1:0] addr_d1;

  // writes trail reads by one cycle, so buffer j+1 takes buffer j's read
  always_ff @(posedge clk) begin
    if (valid_d1)
      for (int j = 0; j < L; j++)
        mem[j][addr_d1] <= line_d[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_d   <= '{default: '0};
      valid_d1 <= 1'b0;
      hs_d1    <= 1'b0;
      vs_d1    <= 1'b0;
      first_d1 <= 1'b0;
      row_d1   <= '0;
      addr_d1  <= '0;
    end else begin
      valid_d1 <= io.pre_frame_valid;
      hs_d1    <= io.pre_frame_hsync;
      vs_d1    <= io.pre_frame_vsync;
      row_d1   <= row_cur;
      if (io.pre_frame_valid) begin
        line_d[0] <= io.pre_img;
        for (int j = 0; j < L; j++)
          line_d[j+1] <= mem[j][addr];
        first_d1 <= (cur == '0);
        addr_d1  <= addr;
      end
    end
  end

  pix_t src [K];
  pix_t win [K][K];
  pix_t win_nxt [K][K];
  logic valid_d2, hs_d2, vs_d2;

  always_comb begin
    src = '{default: '0};
    for (int r = 0; r < K; r++) begin
      if (K - 1 - r <= int'(row_d1))
        src[r] = line_d[K-1-r];
      else if (BORDER != 0)
        src[r] = line_d[row_d1];
      else
        src[r] = '0;
    end
  end

  always_comb begin
    win_nxt = win;
    if (!hs_d1) begin
      win_nxt = '{default: '0};
    end else if (valid_d1) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win_nxt[r][c] = !first_d1 ? win[r][c+1] :
                          (BORDER != 0) ? src[r] : '0;
        win_nxt[r][K-1] = src[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win      <= '{default: '0};
      valid_d2 <= 1'b0;
      hs_d2    <= 1'b0;
      vs_d2    <= 1'b0;
    end else begin
      win      <= win_nxt;
      valid_d2 <= valid_d1;
      hs_d2    <= hs_d1;
      vs_d2    <= vs_d1;
    end
  end

  logic [K*K*DW-1:0] data;

  always_comb begin
    data = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        data[(r*K+c)*DW +: DW] = win[r][c];
  end

  assign io.matrix_data        = data;
  assign io.matrix_frame_valid = valid_d2;
  assign io.matrix_frame_hsync = hs_d2;
  assign io.matrix_frame_vsync = vs_d2;
  assign io.line_overflow      = overflow;
endmodule

// File: tb/tb_matrix_generate_nxn.sv
// Directed bench: K=3, IMG_W=8, 4x4 frames, zero-pad and edge-replicate
// instances fed the same stream.
module tb_matrix_generate_nxn;
  localparam int DW = 8;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int WD = K * K * DW;

  logic clk = 1'b0;
  logic rst_n;
  logic vs, hs, v;
  logic [DW-1:0] img;

  always #5 clk = ~clk;

  matrix_generate_nxn_if #(.DW(DW), .K(K)) b0 ();
  matrix_generate_nxn_if #(.DW(DW), .K(K)) b1 ();

  assign b0.pre_frame_vsync = vs;
  assign b0.pre_frame_hsync = hs;
  assign b0.pre_frame_valid = v;
  assign b0.pre_img         = img;
  assign b1.pre_frame_vsync = vs;
  assign b1.pre_frame_hsync = hs;
  assign b1.pre_frame_valid = v;
  assign b1.pre_img         = img;

  matrix_generate_nxn #(
    .DW(DW), .K(K), .IMG_W(W), .BORDER(0)
  ) dut0 (.clk(clk), .rst_n(rst_n), .io(b0));

  matrix_generate_nxn #(
    .DW(DW), .K(K), .IMG_W(W), .BORDER(1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .io(b1));

  int checks = 0;
  int errors = 0;
  logic [WD-1:0] log0 [$];
  logic [WD-1:0] log1 [$];

  always @(negedge clk) begin
    if (b0.matrix_frame_valid) log0.push_back(b0.matrix_data);
    if (b1.matrix_frame_valid) log1.push_back(b1.matrix_data);
  end

  task automatic chkw(input string tag,
                      input logic [WD-1:0] got, exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic got, exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [WD-1:0] w3(
    input logic [7:0] a, b, c, d, e, f, g, h, i);
    return {i, h, g, f, e, d, c, b, a};
  endfunction

  function automatic logic [7:0] px(input int y, x);
    return 8'(16 * (y + 1) + x + 1);
  endfunction

  task automatic drive(input logic s_v, s_h, s_d,
                       input logic [7:0] p);
    vs = s_v; hs = s_h; v = s_d; img = p;
    @(negedge clk);
  endtask

  task automatic line(input int y, n);
    for (int x = 0; x < n; x++) drive(1, 1, 1, px(y, x));
    repeat (3) drive(1, 0, 0, 8'h00);
  endtask

  logic [WD-1:0] m33, b21, w31, w33, f0, f1;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    m33 = w3(8'h11, 8'h12, 8'h13, 8'h21, 8'h22, 8'h23,
             8'h31, 8'h32, 8'h33);
    b21 = w3(8'h11, 8'h11, 8'h11, 8'h11, 8'h11, 8'h11,
             8'h21, 8'h21, 8'h21);
    w31 = w3(8'h00, 8'h21, 8'h22, 8'h00, 8'h31, 8'h32,
             8'h00, 8'h41, 8'h42);
    w33 = w3(8'h22, 8'h23, 8'h24, 8'h32, 8'h33, 8'h34,
             8'h42, 8'h43, 8'h44);
    f0  = w3(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h11);
    f1  = {9{8'h11}};

    vs = 0; hs = 0; v = 0; img = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chkw("rst_data0", b0.matrix_data, '0);
    chkw("rst_data1", b1.matrix_data, '0);
    chkb("rst_vs", b0.matrix_frame_vsync, 1'b0);
    chkb("rst_hs", b0.matrix_frame_hsync, 1'b0);
    chkb("rst_valid", b0.matrix_frame_valid, 1'b0);
    chkb("rst_ovf", b0.line_overflow, 1'b0);
    rst_n = 1'b1;

    // frame A
    drive(1, 0, 0, 8'h00);
    chkb("vs_d1", b0.matrix_frame_vsync, 1'b0);
    drive(1, 0, 0, 8'h00);
    chkb("vs_d2", b0.matrix_frame_vsync, 1'b1);
    drive(1, 1, 1, 8'h11);
    chkb("valid_d1", b0.matrix_frame_valid, 1'b0);
    chkb("hs_d1", b0.matrix_frame_hsync, 1'b0);
    drive(1, 1, 1, 8'h12);
    chkw("first0", b0.matrix_data, f0);
    chkw("first1", b1.matrix_data, f1);
    chkb("first_valid", b0.matrix_frame_valid, 1'b1);
    chkb("first_hs", b0.matrix_frame_hsync, 1'b1);
    drive(1, 1, 1, 8'h13);
    drive(1, 1, 1, 8'h14);
    repeat (3) drive(1, 0, 0, 8'h00);
    line(1, 4);
    line(2, 4);

    drive(1, 1, 1, px(3, 0));
    drive(1, 1, 1, px(3, 1));
    drive(1, 1, 0, 8'h00);
    chkw("gap_w31", b0.matrix_data, w31);
    chkb("gap_valid1", b0.matrix_frame_valid, 1'b1);
    drive(1, 1, 0, 8'h00);
    chkw("gap_hold1", b0.matrix_data, w31);
    chkb("gap_valid0", b0.matrix_frame_valid, 1'b0);
    chkb("gap_hs", b0.matrix_frame_hsync, 1'b1);
    drive(1, 1, 0, 8'h00);
    chkw("gap_hold2", b0.matrix_data, w31);
    drive(1, 1, 1, px(3, 2));
    chkw("gap_hold3", b0.matrix_data, w31);
    chkb("gap_valid0b", b0.matrix_frame_valid, 1'b0);
    drive(1, 1, 1, px(3, 3));
    chkb("resume_valid", b0.matrix_frame_valid, 1'b1);
    drive(1, 0, 0, 8'h00);
    chkw("w33", b0.matrix_data, w33);
    chkw("w33_b1", b1.matrix_data, w33);
    chkb("hs_fall_d1", b0.matrix_frame_hsync, 1'b1);
    drive(1, 0, 0, 8'h00);
    chkw("clr0", b0.matrix_data, '0);
    chkw("clr1", b1.matrix_data, '0);
    chkb("hs_fall_d2", b0.matrix_frame_hsync, 1'b0);
    chkb("clr_valid", b0.matrix_frame_valid, 1'b0);
    drive(1, 0, 0, 8'h00);

    chki("logA_n0", log0.size(), 16);
    chki("logA_n1", log1.size(), 16);
    if (log0.size() == 16 && log1.size() == 16) begin
      chkw("A_33_b0", log0[10], m33);
      chkw("A_33_b1", log1[10], m33);
      chkw("A_21_b0", log0[4],
           w3(0, 0, 0, 0, 0, 8'h11, 0, 0, 8'h21));
      chkw("A_21_b1", log1[4], b21);
      chkw("A_12_b1", log1[1],
           w3(8'h11, 8'h11, 8'h12, 8'h11, 8'h11, 8'h12,
              8'h11, 8'h11, 8'h12));
      chkw("A_44_b0", log0[15], w33);
    end

    // frame B: over-long first line
    repeat (2) drive(0, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    for (int x = 0; x < 8; x++) drive(1, 1, 1, px(0, x));
    chkb("ovf_8th", b0.line_overflow, 1'b0);
    drive(1, 1, 1, px(0, 8));
    chkb("ovf_9th0", b0.line_overflow, 1'b1);
    chkb("ovf_9th1", b1.line_overflow, 1'b1);
    drive(1, 1, 1, px(0, 9));
    repeat (3) drive(1, 0, 0, 8'h00);
    chkb("ovf_blank", b0.line_overflow, 1'b1);
    line(1, 4);
    repeat (2) drive(0, 0, 0, 8'h00);
    chkb("ovf_vs_low", b0.line_overflow, 1'b1);
    drive(1, 0, 0, 8'h00);
    chkb("ovf_clr0", b0.line_overflow, 1'b0);
    chkb("ovf_clr1", b1.line_overflow, 1'b0);

    // frame C
    log0.delete();
    log1.delete();
    line(0, 4);
    line(1, 4);
    line(2, 4);
    chki("logC_n0", log0.size(), 12);
    if (log0.size() == 12 && log1.size() == 12) begin
      chkw("C_33_b0", log0[10], m33);
      chkw("C_21_b1", log1[4], b21);
      chkw("C_33_b1", log1[10], m33);
    end

    // frame D: reset during line 2
    repeat (2) drive(0, 0, 0, 8'h00);
    drive(1, 0, 0, 8'h00);
    line(0, 4);
    line(1, 4);
    drive(1, 1, 1, px(2, 0));
    drive(1, 1, 1, px(2, 1));
    drive(1, 1, 1, px(2, 2));
    #2 rst_n = 1'b0;
    #1;
    chkw("arst_data0", b0.matrix_data, '0);
    chkw("arst_data1", b1.matrix_data, '0);
    chkb("arst_vs", b0.matrix_frame_vsync, 1'b0);
    chkb("arst_hs", b1.matrix_frame_hsync, 1'b0);
    chkb("arst_valid", b0.matrix_frame_valid, 1'b0);
    vs = 0; hs = 0; v = 0; img = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 8'h00);
    drive(1, 1, 1, 8'h11);
    drive(1, 1, 1, 8'h12);
    chkw("post_rst0", b0.matrix_data, f0);
    chkw("post_rst1", b1.matrix_data, f1);
    chkb("post_rst_valid", b0.matrix_frame_valid, 1'b1);
    repeat (3) drive(1, 0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
